// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Bridges the execute stage and a word-organised data memory. Byte, halfword
//   and word requests are given as byte addresses and turned into word
//   accesses. Sub-word stores become a read-modify-write sequence. Load results
//   are sign- or zero-extended. The unit raises busy while a request is in
//   flight so the pipeline can stall on it.
//
//   The data memory registers its address and performs writes on the falling
//   clock edge. This block updates only on the rising edge. A word read
//   therefore returns its data at the rising edge that closes the cycle in
//   which the address was driven.
//
// Ports:
//   clock, reset        rising-edge clock; synchronous active-high reset
//   req_valid           request present; taken only while busy = 0
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 halfword, 10 word, 11 reserved (error)
//   req_signed          loads only: 1 sign-extends, 0 zero-extends
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   busy                high in every state except IDLE
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load result; 0 for stores and errors
//   resp_error          request rejected; no memory access was made
//   mem_write_enable    data memory write strobe (WRITE state only)
//   mem_address         word index, zero-extended req_addr[ADDR_WIDTH+1:2]
//   mem_input_data      word to be written to memory
//   mem_output_data     word read from memory
//
// Optional feature (macro LSU_RANGE_CHECK_EN):
//   When defined, a request with any req_addr bit at or above ADDR_WIDTH+2 set
//   is rejected with resp_error. When undefined, those bits are ignored and the
//   word index wraps modulo 2**ADDR_WIDTH.
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_WIDTH = 32,  // lane logic assumes exactly 4 bytes
    parameter int ADDR_WIDTH = 10   // log2 of memory depth in words
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_input_data,
    input  logic [DATA_WIDTH-1:0] mem_output_data
);

    // Only the byte-address bits that reach the memory are kept after the
    // request is accepted.
    localparam int LA = ADDR_WIDTH + 2;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [LA-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_error_q, resp_error_d;
    logic [DATA_WIDTH-1:0] mem_input_data_q, mem_input_data_d;

    // ------------------------------------------------------------------
    // Request error decode (evaluated on the incoming request)
    // ------------------------------------------------------------------
    logic req_err;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SIZE_BYTE: req_err = 1'b0;
            SIZE_HALF: req_err = req_addr[0];
            SIZE_WORD: req_err = (req_addr[1:0] != 2'b00);
            default:   req_err = 1'b1;
        endcase
`ifdef LSU_RANGE_CHECK_EN
        // Addresses beyond the memory are rejected rather than aliased.
        if (|req_addr[DATA_WIDTH-1:LA]) begin
            req_err = 1'b1;
        end
`endif
    end

`ifndef LSU_RANGE_CHECK_EN
    // Upper address bits are deliberately ignored: the word index wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:LA];
`endif

    // ------------------------------------------------------------------
    // Lane handling on the word read back from memory
    // ------------------------------------------------------------------
    logic [7:0]            rd_byte [0:3];
    logic [3:0]            byte_en;
    logic [7:0]            wr_lane [0:3];
    logic [DATA_WIDTH-1:0] merged_word;

    // Byte lanes touched by the latched request (little-endian).
    always_comb begin
        byte_en = 4'b0000;
        case (size_q)
            SIZE_BYTE: byte_en = 4'b0001 << addr_q[1:0];
            SIZE_HALF: byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default:   byte_en = 4'b1111;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = mem_output_data[gi*8 +: 8];

            // Store data is right-aligned, so a byte store replicates its low
            // byte to every lane and a halfword store its low halfword to
            // both halves; byte_en then picks the lane(s) actually written.
            always_comb begin
                case (size_q)
                    SIZE_BYTE: wr_lane[gi] = wdata_q[7:0];
                    SIZE_HALF: wr_lane[gi] = wdata_q[(gi % 2)*8 +: 8];
                    default:   wr_lane[gi] = wdata_q[gi*8 +: 8];
                endcase
            end

            assign merged_word[gi*8 +: 8] = byte_en[gi] ? wr_lane[gi] : rd_byte[gi];
        end
    endgenerate

    // Load extraction and extension.
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] load_result;

    assign sel_byte = rd_byte[addr_q[1:0]];
    assign sel_half = addr_q[1] ? mem_output_data[31:16] : mem_output_data[15:0];

    always_comb begin
        case (size_q)
            SIZE_BYTE: load_result = {{(DATA_WIDTH-8){signed_q & sel_byte[7]}}, sel_byte};
            SIZE_HALF: load_result = {{(DATA_WIDTH-16){signed_q & sel_half[15]}}, sel_half};
            default:   load_result = mem_output_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        size_d           = size_q;
        signed_d         = signed_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        mem_input_data_d = mem_input_data_q;
        // Response fields are pulses: they are only non-zero on entry to RESP,
        // which also clears resp_rdata on entry to any other state.
        resp_valid_d     = 1'b0;
        resp_rdata_d     = '0;
        resp_error_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr[LA-1:0];
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (!req_write) begin
                        state_d = READ;
                    end else if (req_size == SIZE_WORD) begin
                        // Full-word stores need no read of the old word.
                        state_d          = WRITE;
                        mem_input_data_d = req_wdata;
                    end else begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                // mem_output_data reflects mem_address at this closing edge.
                if (write_q) begin
                    mem_input_data_d = merged_word;
                    state_d          = WRITE;
                end else begin
                    resp_rdata_d = load_result;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end

            WRITE: begin
                // The memory commits on the falling edge inside this cycle.
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            resp_error_q     <= 1'b0;
            mem_input_data_q <= '0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            size_q           <= size_d;
            signed_q         <= signed_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_error_q     <= resp_error_d;
            mem_input_data_q <= mem_input_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy             = (state_q != IDLE);
    assign mem_write_enable = (state_q == WRITE);
    assign mem_address      = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, addr_q[LA-1:2]};
    assign mem_input_data   = mem_input_data_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_error       = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A falling-edge data memory is
// modelled next to the DUT. Expected results come from a byte-level reference
// model of the memory contents and the access rules (alignment, size,
// extension, latency). Directed steps follow the test plan, then a randomized
// run follows.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_input_data;
    logic [31:0] mem_output_data;

    int n_checks;
    int n_fail;

    load_store_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(10)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .busy             (busy),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_input_data   (mem_input_data),
        .mem_output_data  (mem_output_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Data memory: address registered and writes performed on the falling edge.
    logic [31:0] phys_mem [0:1023];
    logic [9:0]  mem_addr_reg;
    int          wr_count;

    always @(negedge clock) begin
        if (mem_write_enable) begin
            phys_mem[mem_address[9:0]] <= mem_input_data;
            wr_count <= wr_count + 1;
        end
        mem_addr_reg <= mem_address[9:0];
    end

    assign mem_output_data = phys_mem[mem_addr_reg];

    // Reference memory contents.
    logic [31:0] ref_mem [0:1023];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: applies the access rules at byte granularity and
    // updates ref_mem for accepted stores.
    task automatic ref_access(input logic w, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output logic [31:0] rdata,
                              output int lat, output int nwr);
        int idx;
        int off;
        int nb;
        int p;
        longint unsigned word;
        longint unsigned mask;
        longint unsigned val;
        idx = int'(addr[11:2]);
        off = int'(addr[1:0]);
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((off % nb) != 0);
`ifdef LSU_RANGE_CHECK_EN
        if ((addr >> 12) != 0) err = 1'b1;
`endif
        rdata = 32'd0;
        nwr   = 0;
        if (err) begin
            lat = 1;
        end else if (!w) begin
            word = {32'd0, ref_mem[idx]};
            mask = (64'd1 << (8 * nb)) - 64'd1;
            val  = (word >> (8 * off)) & mask;
            if (sgn && nb < 4 && ((val >> (8 * nb - 1)) & 64'd1) != 0) val = val | ~mask;
            rdata = val[31:0];
            lat   = 2;
        end else begin
            for (int b = 0; b < nb; b++) begin
                p = 8 * (off + b);
                ref_mem[idx][p +: 8] = wdata[8*b +: 8];
            end
            lat = (nb == 4) ? 2 : 3;
            nwr = 1;
        end
    endtask

    // Issue one request, wait (bounded) for its response and check it.
    task automatic do_req(input string tag, input logic w, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata_obs);
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat;
        int          e_nwr;
        int          lat;
        int          wr0;
        int          idx;
        ref_access(w, size, sgn, addr, wdata, e_err, e_rdata, e_lat, e_nwr);
        idx        = int'(addr[11:2]);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        wr0        = wr_count;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        rdata_obs = resp_rdata;
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
        check({tag, " resp_error"}, {31'd0, resp_error}, {31'd0, e_err});
        check({tag, " resp_rdata"}, resp_rdata, e_rdata);
        check({tag, " write_pulses"}, 32'(wr_count - wr0), 32'(e_nwr));
        check({tag, " mem_word"}, phys_mem[idx], ref_mem[idx]);
        $display("txn %s: w=%0d size=%0d signed=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 tag, w, size, sgn, addr, wdata, resp_rdata, resp_error, lat);
        @(posedge clock); #1;
        check({tag, " back_to_idle"}, {30'd0, busy, resp_valid}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] rd;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic [1:0]  size_r;
    logic        w_r;
    logic        sgn_r;
    int          wr0;
    int          nbusy;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_error", {31'd0, resp_error}, 32'd0);
        check("reset mem_we", {31'd0, mem_write_enable}, 32'd0);
        check("reset mem_address", mem_address, 32'd0);
        check("reset mem_input_data", mem_input_data, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Fill the 16 words used by the run with known contents.
        for (int i = 0; i < 16; i++) begin
            do_req("fill", 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom(), rd);
        end

        // Word store then word load
        do_req("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
        check("sw_10 index4", phys_mem[4], 32'hDEADBEEF);
        do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd);
        check("lw_10 value", rd, 32'hDEADBEEF);

        // Byte store into word 0x11223344, then byte loads
        do_req("sw_base", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rd);
        do_req("sb_13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, rd);
        check("sb_13 word", phys_mem[4], 32'hA5223344);
        do_req("lb_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, rd);
        check("lb_13 value", rd, 32'hFFFFFFA5);
        do_req("lbu_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, rd);
        check("lbu_13 value", rd, 32'h000000A5);

        // Halfword loads and misaligned halfword
        do_req("sw_half", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80017FFF, rd);
        do_req("lhu_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, rd);
        check("lhu_12 value", rd, 32'h00008001);
        do_req("lh_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'd0, rd);
        check("lh_12 value", rd, 32'hFFFF8001);
        do_req("lh_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, rd);
        check("lh_10 value", rd, 32'h00007FFF);
        do_req("lh_11_err", 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, rd);
        do_req("sh_11_err", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BEEF, rd);
        do_req("sw_12_err", 1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, rd);
        do_req("size3_err", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, rd);

        // Request held through a sub-word store; a new one follows after RESP
        addr_r = 32'h05;
        begin
            logic        e_err;
            logic [31:0] e_rdata;
            int          e_lat;
            int          e_nwr;
            ref_access(1'b1, 2'b00, 1'b0, addr_r, 32'h0000003C, e_err, e_rdata, e_lat, e_nwr);
        end
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = addr_r;
        req_wdata  = 32'h0000003C;
        wr0        = wr_count;
        @(posedge clock); #1;
        nbusy = 0;
        while (busy && nbusy < 8) begin
            nbusy++;
            @(posedge clock); #1;
        end
        check("hold busy_cycles", 32'(nbusy), 32'd3);
        check("hold write_pulses", 32'(wr_count - wr0), 32'd1);
        check("hold mem_word", phys_mem[1], ref_mem[1]);
        $display("txn hold_sb: addr=%h busy_cycles=%0d writes=%0d", addr_r, nbusy, wr_count - wr0);
        // req_valid is still high here; switch to the follow-on load.
        do_req("hold_lbu", 1'b0, 2'b00, 1'b0, addr_r, 32'd0, rd);
        check("hold_lbu value", rd, 32'h0000003C);

        // Reset during READ of a byte store: no write, no response
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h21;
        req_wdata  = 32'h000000EE;
        wr0        = wr_count;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("rst_read busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_read busy", {31'd0, busy}, 32'd0);
        check("rst_read resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (3) begin
            @(posedge clock); #1;
            check("rst_read no_resp", {31'd0, resp_valid}, 32'd0);
        end
        check("rst_read writes", 32'(wr_count - wr0), 32'd0);
        check("rst_read mem_word", phys_mem[8], ref_mem[8]);
        $display("txn rst_in_read: addr=%h writes=%0d word=%h", 32'h21, wr_count - wr0, phys_mem[8]);

        // Reset during WRITE of a word store: the write lands, no response
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_addr   = 32'h24;
        req_wdata  = 32'hCAFEF00D;
        wr0        = wr_count;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        ref_mem[9] = 32'hCAFEF00D;
        check("rst_write busy", {31'd0, busy}, 32'd0);
        check("rst_write resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_write writes", 32'(wr_count - wr0), 32'd1);
        check("rst_write mem_word", phys_mem[9], 32'hCAFEF00D);
        @(posedge clock); #1;
        check("rst_write no_resp", {31'd0, resp_valid}, 32'd0);
        $display("txn rst_in_write: addr=%h writes=%0d word=%h", 32'h24, wr_count - wr0, phys_mem[9]);

        // Address beyond memory depth
        do_req("lw_1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, rd);
`ifdef LSU_RANGE_CHECK_EN
        check("lw_1000 error", {31'd0, resp_error}, 32'd1);
`else
        check("lw_1000 index0", rd, phys_mem[0]);
`endif

        // Randomized requests against the reference model
        for (int i = 0; i < 300; i++) begin
            w_r    = 1'($urandom_range(0, 1));
            size_r = 2'($urandom_range(0, 3));
            sgn_r  = 1'($urandom_range(0, 1));
            addr_r = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) addr_r = addr_r | ($urandom() << 12);
            data_r = $urandom();
            do_req("rand", w_r, size_r, sgn_r, addr_r, data_r, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
